// File: rtl/qpd_pkg.sv
// Shared definitions for the quadrant-photodiode normaliser: FSM encoding,
// default geometry and the constants derived from it.
package qpd_pkg;

    // Sequencer states: wait for a sample, run the dividers, publish the result.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_OUTPUT = 2'd2
    } qpd_state_t;

    localparam int DEF_IN_BITS  = 16;
    localparam int DEF_IN_FRAC  = 15;
    localparam int DEF_OUT_BITS = 16;
    localparam int DEF_OUT_FRAC = 15;

    // Largest representable magnitude of a clipped ratio (just below 1.0).
    localparam int SAT_MAG    = (1 << DEF_OUT_FRAC) - 1;
    // Width of the iteration counter for the default fractional size.
    localparam int ITER_CNT_W = $clog2(DEF_OUT_FRAC + 1);

    // Iteration-counter width for an arbitrary fractional size.
    function automatic int iter_cnt_w(input int frac_bits);
        return $clog2(frac_bits + 1);
    endfunction

endpackage

// File: rtl/qpd_normalizer_serial_frac_divider.sv
// Restoring bit-serial fractional divider: |num| / den with one quotient bit
// per step, MSB first, sign applied to the finished quotient.
module serial_frac_divider #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int FRAC  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [IN_W:0]    mag_i,
    input  logic             neg_i,
    input  logic [IN_W-1:0]  den_i,
    output logic [OUT_W-1:0] quot_o
);

    logic [IN_W:0]    rem_q, rem_d;
    logic [FRAC-1:0]  quo_q, quo_d;
    logic             neg_q, neg_d;
    logic [IN_W+1:0]  shifted_s;
    logic [IN_W+1:0]  den_ext_s;
    logic [IN_W+1:0]  diff_s;
    logic [OUT_W-1:0] mag_ext_s;

    // Load on start, otherwise perform one shift/compare/subtract per step.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_d     = neg_q;
        shifted_s = {rem_q, 1'b0};
        den_ext_s = {2'b00, den_i};
        diff_s    = shifted_s - den_ext_s;
        if (start_i) begin
            rem_d = mag_i;
            quo_d = '0;
            neg_d = neg_i;
        end else if (step_i) begin
            if (shifted_s >= den_ext_s) begin
                rem_d = diff_s[IN_W:0];
                quo_d = {quo_q[FRAC-2:0], 1'b1};
            end else begin
                rem_d = shifted_s[IN_W:0];
                quo_d = {quo_q[FRAC-2:0], 1'b0};
            end
        end else begin
            rem_d = rem_q;
        end
    end

    // Divider working registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            neg_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            neg_q <= neg_d;
        end
    end

    // Zero-extend the magnitude and negate it for a negative numerator.
    always_comb begin
        mag_ext_s = OUT_W'(quo_q);
        if (neg_q) begin
            quot_o = -mag_ext_s;
        end else begin
            quot_o = mag_ext_s;
        end
    end

endmodule

// File: rtl/qpd_normalizer.sv
// Normalises QPD difference signals by the total intensity: x = XDIFF/SUM,
// y = YDIFF/SUM, with low-light and saturation guards and fixed latency.
module qpd_normalizer
    import qpd_pkg::*;
#(
    parameter int inputBitSize   = DEF_IN_BITS,
    parameter int inputFracSize  = DEF_IN_FRAC,
    parameter int outputBitSize  = DEF_OUT_BITS,
    parameter int outputFracSize = DEF_OUT_FRAC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [inputBitSize-1:0]  XDIFF,
    input  logic [inputBitSize-1:0]  YDIFF,
    input  logic [inputBitSize-1:0]  SUM,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [inputBitSize-1:0]  min_sum,
    output logic [outputBitSize-1:0] x,
    output logic [outputBitSize-1:0] y,
    output logic [inputBitSize-1:0]  sum_out,
    output logic                     out_valid,
    output logic                     low_light,
    output logic [1:0]               saturated
);

    localparam int CNT_W = iter_cnt_w(outputFracSize);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(outputFracSize - 1);
    localparam logic [outputBitSize-1:0] SAT_VAL =
        outputBitSize'((1 << outputFracSize) - 1);

    // Reject geometries where the result cannot hold its fraction, or the
    // input fraction exceeds the magnitude bits of a signed word.
    generate
        if ((outputBitSize < outputFracSize + 1) ||
            (inputFracSize > inputBitSize - 1)) begin : g_param_check
            $error("qpd_normalizer: unsupported parameter combination");
        end
    endgenerate

    qpd_state_t              state_q, state_d;
    logic [CNT_W-1:0]        iter_q, iter_d;
    logic                    accept_s;
    logic                    step_s;

    logic [inputBitSize:0]   xmag_s, ymag_s;
    logic                    low_s, xsat_s, ysat_s;

    logic [inputBitSize-1:0] sum_cap_q;
    logic                    low_cap_q;
    logic [1:0]              sat_cap_q;
    logic                    xneg_cap_q, yneg_cap_q;

    logic [outputBitSize-1:0] quot_x_s, quot_y_s;
    logic [outputBitSize-1:0] x_res_s, y_res_s;

    logic [outputBitSize-1:0] x_q, y_q;
    logic [inputBitSize-1:0]  sum_out_q;
    logic                     out_valid_q, low_light_q, in_ready_q;
    logic [1:0]               saturated_q;

    assign accept_s = (state_q == ST_IDLE) && in_valid;
    assign step_s   = (state_q == ST_DIVIDE);

    // Magnitudes at one extra bit so the most-negative code stays exact,
    // plus the guard decisions taken on the sample being accepted.
    always_comb begin
        if (XDIFF[inputBitSize-1]) begin
            xmag_s = ~{1'b1, XDIFF} + {{inputBitSize{1'b0}}, 1'b1};
        end else begin
            xmag_s = {1'b0, XDIFF};
        end
        if (YDIFF[inputBitSize-1]) begin
            ymag_s = ~{1'b1, YDIFF} + {{inputBitSize{1'b0}}, 1'b1};
        end else begin
            ymag_s = {1'b0, YDIFF};
        end
        low_s  = ($signed(SUM) <= $signed(min_sum)) ||
                 ($signed(SUM) <= $signed({inputBitSize{1'b0}}));
        xsat_s = (xmag_s >= {1'b0, SUM});
        ysat_s = (ymag_s >= {1'b0, SUM});
    end

    // Sequencer next state and iteration counting.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_DIVIDE;
                    iter_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                iter_d = iter_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (iter_q == LAST_ITER) begin
                    state_d = ST_OUTPUT;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_OUTPUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                iter_d  = '0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Capture SUM and the guard decisions alongside the accepted sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_cap_q  <= '0;
            low_cap_q  <= 1'b0;
            sat_cap_q  <= 2'b00;
            xneg_cap_q <= 1'b0;
            yneg_cap_q <= 1'b0;
        end else if (accept_s) begin
            sum_cap_q  <= SUM;
            low_cap_q  <= low_s;
            sat_cap_q  <= low_s ? 2'b00 : {ysat_s, xsat_s};
            xneg_cap_q <= XDIFF[inputBitSize-1];
            yneg_cap_q <= YDIFF[inputBitSize-1];
        end else begin
            sum_cap_q  <= sum_cap_q;
        end
    end

    serial_frac_divider #(
        .IN_W  (inputBitSize),
        .OUT_W (outputBitSize),
        .FRAC  (outputFracSize)
    ) u_div_x (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept_s),
        .step_i  (step_s),
        .mag_i   (xmag_s),
        .neg_i   (XDIFF[inputBitSize-1]),
        .den_i   (sum_cap_q),
        .quot_o  (quot_x_s)
    );

    serial_frac_divider #(
        .IN_W  (inputBitSize),
        .OUT_W (outputBitSize),
        .FRAC  (outputFracSize)
    ) u_div_y (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept_s),
        .step_i  (step_s),
        .mag_i   (ymag_s),
        .neg_i   (YDIFF[inputBitSize-1]),
        .den_i   (sum_cap_q),
        .quot_o  (quot_y_s)
    );

    // Apply the guards: low light forces zero, saturation forces +/- full scale.
    always_comb begin
        if (low_cap_q) begin
            x_res_s = '0;
        end else if (sat_cap_q[0]) begin
            x_res_s = xneg_cap_q ? -SAT_VAL : SAT_VAL;
        end else begin
            x_res_s = quot_x_s;
        end
        if (low_cap_q) begin
            y_res_s = '0;
        end else if (sat_cap_q[1]) begin
            y_res_s = yneg_cap_q ? -SAT_VAL : SAT_VAL;
        end else begin
            y_res_s = quot_y_s;
        end
    end

    // Output registers: results update in OUTPUT and hold; only out_valid pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            sum_out_q   <= '0;
            low_light_q <= 1'b0;
            saturated_q <= 2'b00;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= (state_q == ST_OUTPUT);
            in_ready_q  <= (state_d == ST_IDLE);
            if (state_q == ST_OUTPUT) begin
                x_q         <= x_res_s;
                y_q         <= y_res_s;
                sum_out_q   <= sum_cap_q;
                low_light_q <= low_cap_q;
                saturated_q <= sat_cap_q;
            end else begin
                x_q         <= x_q;
            end
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign sum_out   = sum_out_q;
    assign low_light = low_light_q;
    assign saturated = saturated_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule
